dmem_port: RTL
==============

# dmem_port

Data-memory access stage directly downstream of the ALU in the single-cycle MIPS datapath. It takes the ALU result as the effective address and turns load and store instructions into a req/ack transaction on an external memory bus. It stalls the core until the bus acknowledges, then returns aligned and extended load data to the writeback mux.

## Interface
- N, 32, data/address width; only 32 is supported (4 byte lanes)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  N  effective address (ALU result)
- wdata  in  N  store data (rt register value)
- mem_read  in  1  load instruction in current cycle
- mem_write  in  1  store instruction in current cycle
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal (treated as word)
- load_unsigned  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
- stall  out  1  hold PC and suppress register/PC writeback this cycle
- rdata  out  N  extended load result
- misalign  out  1  one-cycle pulse: access dropped due to misalignment
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  N  word-aligned address (addr[1:0] forced 00)
- bus_wdata  out  N  lane-replicated write data
- bus_be  out  N/8  byte enables, bit k = byte lane k (little-endian)
- bus_ack  in  1  slave completes the request in this cycle
- bus_rdata  in  N  read data, valid when bus_ack=1

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- IDLE: if mem_write or mem_read is high:
  - write has priority if both are high;
  - aligned means half requires addr[0]=0 and word requires addr[1:0]=00;
  - aligned: register bus_addr, bus_we, bus_be, bus_wdata, load lane and size, and load_unsigned; set bus_req=1 and go to REQ;
  - misaligned: misalign=1, stall=0, no bus activity, stay in IDLE. The instruction retires with no memory effect.
- REQ: bus outputs are held stable. When bus_ack=1, drop bus_req; for a load, capture the extended bus_rdata into rdata. Go to DONE.
- DONE: stall=0 so the instruction retires at the end of this cycle. Unconditionally return to IDLE; new requests are not sampled in DONE.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100 by addr[1]
  - word: 1111
- Write data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction selects the lane given by the captured addr[1:0], then sign- or zero-extends it to N.
- rdata holds its value until the next load capture; stores leave it unchanged.
- stall = (IDLE and aligned request) or REQ. stall is combinational and forced to 0 while reset=1.

## Timing
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, misalign=0, stall=0.
- Latency: IDLE (1) + REQ (k ≥ 1 cycles, ack on the k-th) + DONE (1). Minimum 3 cycles per access.
- Non-memory instructions: stall=0 and zero added latency.
- bus_req rises on the edge leaving IDLE and falls on the edge after the bus_ack cycle. It is never asserted in DONE.
- bus_ack outside REQ is ignored.
- Reset asserted during REQ: bus_req=0 after that edge and state is IDLE. The transaction is abandoned, and the slave must tolerate a dropped request.
- misalign is combinational in IDLE; it is high only while the offending instruction is presented.

## Structure
- Shared package dmem_pkg:
  - size_e (BYTE, HALF, WORD)
  - state_e (IDLE, REQ, DONE)
  - constant LANES = 4
- Sub-module load_align (combinational): inputs word, lane, size, unsigned_flag; output extended value. It is reused for future LWL/LWR support.

## Test plan
- Word load: addr=0x100, slave acks after 2 REQ cycles with 0xDEADBEEF. Required: stall high for 3 cycles, bus_addr=0x100, bus_be=1111, rdata=0xDEADBEEF in DONE.
- Signed byte loads from bus_rdata=0x80FF7F01:
  - lb at addr=0x203 → 0xFFFFFF80
  - lbu at addr=0x203 → 0x00000080
  - lb at addr=0x200 → 0x00000001
- Half store: sh wdata=0x1234ABCD at addr=0x302. Required: bus_addr=0x300, bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, rdata unchanged.
- Misaligned: lw at addr=0x101 and lh at addr=0x103. Required: misalign=1 for one cycle, stall=0, bus_req never rises.
- Reset mid-REQ: sb outstanding with no ack; assert reset for 1 cycle. Required: next cycle bus_req=0, stall=0, rdata=0. A following lw completes normally.
- Back-to-back: lw then sw, each slave acks immediately. Required: IDLE→REQ→DONE→IDLE→REQ→DONE, no request issued in DONE, total 6 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access stage: access sizes, FSM states,
// lane decoding and store-data replication.
package dmem_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  // Encoding 2'b11 is illegal and behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] offs);
    case (sz)
      SzByte:  return 1'b1;
      SzHalf:  return ~offs[0];
      default: return offs == 2'b00;
    endcase
  endfunction

  function automatic logic [LANES-1:0] byte_enables(input size_e sz, input logic [1:0] offs);
    case (sz)
      SzByte:  return 4'b0001 << offs;
      SzHalf:  return offs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input size_e sz, input logic [31:0] data);
    case (sz)
      SzByte:  return {4{data[7:0]}};
      SzHalf:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_load_align.sv
// Combinational lane extraction and sign/zero extension of a bus word for loads.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        unsigned_flag,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    value  = word;
    case (size)
      SzByte:  value = {{24{~unsigned_flag & byte_v[7]}}, byte_v};
      SzHalf:  value = {{16{~unsigned_flag & half_v[15]}}, half_v};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// Load/store stage: converts aligned memory instructions into a single req/ack bus transaction,
// stalling the core until DONE, and returns extended load data.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int unsigned N = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   size,
  input  logic         load_unsigned,
  output logic         stall,
  output logic [N-1:0] rdata,
  output logic         misalign,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  output logic [N/8-1:0] bus_be,
  input  logic         bus_ack,
  input  logic [N-1:0] bus_rdata
);

  state_e         state_q, state_d;
  logic           bus_req_q, bus_req_d;
  logic           bus_we_q, bus_we_d;
  logic [N-1:0]   bus_addr_q, bus_addr_d;
  logic [N-1:0]   bus_wdata_q, bus_wdata_d;
  logic [N/8-1:0] bus_be_q, bus_be_d;
  logic [1:0]     lane_q, lane_d;
  size_e          size_q, size_d;
  logic           uns_q, uns_d;
  logic [N-1:0]   rdata_q, rdata_d;

  size_e        req_size;
  logic         req_active;
  logic         req_aligned;
  logic [N-1:0] load_value;

  assign req_size    = decode_size(size);
  assign req_active  = mem_read | mem_write;
  assign req_aligned = is_aligned(req_size, addr[1:0]);

  load_align u_load_align (
    .word          (bus_rdata),
    .lane          (lane_q),
    .size          (size_q),
    .unsigned_flag (uns_q),
    .value         (load_value)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_active && req_aligned) begin
          state_d     = StReq;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;  // store wins when both are asserted
          bus_addr_d  = {addr[N-1:2], 2'b00};
          bus_be_d    = byte_enables(req_size, addr[1:0]);
          bus_wdata_d = replicate(req_size, wdata);
          lane_d      = addr[1:0];
          size_d      = req_size;
          uns_d       = load_unsigned;
        end
      end
      StReq: begin
        if (bus_ack) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = load_value;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      lane_q      <= 2'b00;
      size_q      <= SzWord;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall    = ~reset & (((state_q == StIdle) & req_active & req_aligned) |
                              (state_q == StReq));
  assign misalign = ~reset & (state_q == StIdle) & req_active & ~req_aligned;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign rdata     = rdata_q;

endmodule
